rom_stream_reader: RTL

// Sequencer that drives memoryROM upstream: on start, fetches len words from

---
 rtl/rom_stream_reader_if.sv | 12 +
 rtl/rom_stream_reader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rom_stream_reader_if.sv
// Output word stream of rom_stream_reader: valid/ready handshake with a last-word marker.
interface rom_stream_reader_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic                  last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/rom_stream_reader.sv
// Burst reader for a 1-cycle-latency ROM: issues consecutive reads and streams the words
// out through a 4-entry buffer, throttling reads with credits so the buffer never overflows.
module rom_stream_reader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DATA_DEPTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_DEPTH-1:0] base_addr,
   input  logic [DATA_DEPTH:0]   len,
   output logic                  rom_read,
   output logic [31:0]           rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   rom_stream_reader_if.master   stream,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BufDepth = 4;
   localparam logic [DATA_DEPTH-1:0] AddrOne = 1;
   localparam logic [DATA_DEPTH:0]   LenOne  = 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] buf_data_q [BufDepth];
   logic [BufDepth-1:0]   buf_last_q;
   logic [1:0]            wr_ptr_q, rd_ptr_q;
   logic [2:0]            count_q, count_d;
   logic [DATA_DEPTH-1:0] addr_q, next_addr_q;
   logic [DATA_DEPTH:0]   left_q;
   logic                  read_q, read_last_q;
   logic                  pend_q, pend_last_q;
   logic                  busy_q, done_q;
   logic                  pop, last_pop, credit_ok;

   // Credits count words buffered after this edge plus the read in flight this cycle.
   always_comb begin
      pop       = (count_q != '0) && stream.ready;
      last_pop  = pop && buf_last_q[rd_ptr_q];
      count_d   = count_q + {2'b00, pend_q} - {2'b00, pop};
      credit_ok = (count_d + {2'b00, read_q}) < 3'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         buf_last_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         addr_q      <= '0;
         next_addr_q <= '0;
         left_q      <= '0;
         read_q      <= 1'b0;
         read_last_q <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < BufDepth; i++) begin
            buf_data_q[i] <= '0;
         end
      end else begin
         done_q      <= 1'b0;
         read_q      <= 1'b0;
         read_last_q <= 1'b0;
         pend_q      <= read_q;
         pend_last_q <= read_last_q;
         count_q     <= count_d;
         // The ROM word of last cycle's read lands unconditionally; credits reserved its slot.
         if (pend_q) begin
            buf_data_q[wr_ptr_q] <= rom_data;
            buf_last_q[wr_ptr_q] <= pend_last_q;
            wr_ptr_q             <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q     <= StRun;
                     busy_q      <= 1'b1;
                     read_q      <= 1'b1;
                     read_last_q <= (len == LenOne);
                     addr_q      <= base_addr;
                     next_addr_q <= base_addr + AddrOne;
                     left_q      <= len - LenOne;
                  end
               end
            end
            StRun: begin
               if (left_q == '0) begin
                  state_q <= StDrain;
               end else if (credit_ok) begin
                  read_q      <= 1'b1;
                  read_last_q <= (left_q == LenOne);
                  addr_q      <= next_addr_q;
                  next_addr_q <= next_addr_q + AddrOne;
                  left_q      <= left_q - LenOne;
               end
            end
            StDrain: begin
            end
            default: state_q <= StIdle;
         endcase
         if ((state_q != StIdle) && last_pop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
         end
      end
   end

   assign rom_read     = read_q;
   assign rom_addr     = {{(32 - DATA_DEPTH){1'b0}}, addr_q};
   assign stream.valid = (count_q != '0);
   assign stream.data  = buf_data_q[rd_ptr_q];
   assign stream.last  = (count_q != '0) && buf_last_q[rd_ptr_q];
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
